reset_seq_ctrl: RTL and testbench

//  Board-level reset sequencer sitting between the power-on reset source and the capture/USB/RAM domains.

---
 rtl/reset_seq_ctrl_pkg.sv | 16 +
 rtl/reset_seq_ctrl_sync.sv | 23 ++
 rtl/reset_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_reset_seq_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_ctrl_pkg.sv
// Shared definitions for the board reset sequencer: FSM state encoding and
// the width of the failing-domain index.
package reset_seq_ctrl_pkg;

  localparam int FAIL_IDX_W = 3;

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_RELEASE = 3'd1,
    S_WAIT    = 3'd2,
    S_DONE    = 3'd3,
    S_ERROR   = 3'd4,
    S_ASSERT  = 3'd5
  } state_e;

endpackage

// File: rtl/reset_seq_ctrl_sync.sv
// Reset synchroniser: asserts asynchronously with rst_ni, deasserts after
// SYNC_STAGES rising edges of clk_i.
module reset_seq_ctrl_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_no
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_no = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_seq_ctrl.sv
// Board-level reset sequencer: releases NUM_DOMAINS domain resets in index
// order, each gated by a ready handshake with timeout; soft reset unwinds them.
module reset_seq_ctrl
  import reset_seq_ctrl_pkg::*;
#(
  parameter int NUM_DOMAINS    = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int DELAY_CYCLES   = 1024,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   soft_rst_i,
  input  logic [NUM_DOMAINS-1:0] ready_i,
  output logic [NUM_DOMAINS-1:0] rst_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [FAIL_IDX_W-1:0]  fail_idx_o
);

  localparam int DLY_W = $clog2(DELAY_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DLY_W-1:0]      DLY_LAST = DLY_W'(DELAY_CYCLES - 1);
  localparam logic [TO_W-1:0]       TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FAIL_IDX_W-1:0] LAST_IDX = FAIL_IDX_W'(NUM_DOMAINS - 1);

  function automatic logic [DLY_W-1:0] dly_inc(input logic [DLY_W-1:0] c);
    return (c == {DLY_W{1'b1}}) ? c : c + DLY_W'(1);
  endfunction

  function automatic logic [TO_W-1:0] to_inc(input logic [TO_W-1:0] c);
    return (c == {TO_W{1'b1}}) ? c : c + TO_W'(1);
  endfunction

  function automatic logic [NUM_DOMAINS-1:0] dom_sel(input logic [FAIL_IDX_W-1:0] i);
    logic [NUM_DOMAINS-1:0] m;
    m = '0;
    for (int k = 0; k < NUM_DOMAINS; k++) begin
      if (FAIL_IDX_W'(k) == i) m[k] = 1'b1;
    end
    return m;
  endfunction

  logic                   rst_int_n;
  state_e                 state;
  logic [FAIL_IDX_W-1:0]  idx;
  logic [DLY_W-1:0]       dly_cnt;
  logic [TO_W-1:0]        to_cnt;
  logic [NUM_DOMAINS-1:0] sel;
  logic                   ready_hit;

  reset_seq_ctrl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .rst_no (rst_int_n)
  );

  assign sel       = dom_sel(idx);
  assign ready_hit = |(ready_i & sel);

  // Sequencer FSM; soft reset outranks ready, ready outranks timeout
  always_ff @(posedge clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state      <= S_HOLD;
      idx        <= '0;
      dly_cnt    <= '0;
      to_cnt     <= '0;
      rst_o      <= '1;
      done_o     <= 1'b0;
      error_o    <= 1'b0;
      fail_idx_o <= '0;
    end else begin
      unique case (state)
        S_HOLD: begin
          if (soft_rst_i) begin
            dly_cnt <= '0;
            if (idx != '0) begin
              idx   <= idx - 1'b1;
              state <= S_ASSERT;
            end
          end else if (dly_cnt == DLY_LAST) begin
            dly_cnt <= '0;
            state   <= S_RELEASE;
          end else begin
            dly_cnt <= dly_inc(dly_cnt);
          end
        end
        S_RELEASE: begin
          to_cnt <= '0;
          if (soft_rst_i) begin
            state <= S_ASSERT;
          end else begin
            rst_o <= rst_o & ~sel;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (soft_rst_i) begin
            state <= S_ASSERT;
          end else if (ready_hit) begin
            if (idx == LAST_IDX) begin
              done_o <= 1'b1;
              state  <= S_DONE;
            end else begin
              idx     <= idx + 1'b1;
              dly_cnt <= '0;
              state   <= S_HOLD;
            end
          end else if (to_cnt == TO_LAST) begin
            error_o    <= 1'b1;
            fail_idx_o <= idx;
            state      <= S_ERROR;
          end else begin
            to_cnt <= to_inc(to_cnt);
          end
        end
        S_DONE: begin
          if (soft_rst_i) begin
            done_o <= 1'b0;
            state  <= S_ASSERT;
          end
        end
        S_ERROR: begin
          if (soft_rst_i) begin
            error_o    <= 1'b0;
            fail_idx_o <= '0;
            state      <= S_ASSERT;
          end
        end
        S_ASSERT: begin
          rst_o <= rst_o | sel;
          if (idx == '0) begin
            dly_cnt <= '0;
            state   <= S_HOLD;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: state <= S_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Bench for reset_seq_ctrl: event-time reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_reset_seq_ctrl;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int DC = 8;
  localparam int TC = 32;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         soft_rst_i;
  logic [N-1:0] ready_i;
  logic [N-1:0] rst_o;
  logic         done_o;
  logic         error_o;
  logic [2:0]   fail_idx_o;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  reset_seq_ctrl #(
    .NUM_DOMAINS(N), .SYNC_STAGES(SS), .DELAY_CYCLES(DC), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .soft_rst_i (soft_rst_i),
    .ready_i    (ready_i),
    .rst_o      (rst_o),
    .done_o     (done_o),
    .error_o    (error_o),
    .fail_idx_o (fail_idx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: tracks how many domains are released and the absolute
  // edge numbers at which the next release / timeout are due.
  int cyc = 0, sync_cnt = 0, n_rel = 0, t_rel = -1, t_to = -1, retract_left = 0;
  bit awaiting = 1'b0, m_done = 1'b0, m_err = 1'b0;
  int m_fail = 0;

  initial begin
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        sync_cnt = 0; n_rel = 0; t_rel = -1; t_to = -1; retract_left = 0;
        awaiting = 1'b0; m_done = 1'b0; m_err = 1'b0; m_fail = 0;
      end else begin
        cyc++;
        if (sync_cnt < SS) begin
          sync_cnt++;
          if (sync_cnt == SS) t_rel = cyc + DC + 1;
        end else if (retract_left > 0) begin
          if (retract_left <= n_rel) n_rel--;
          retract_left--;
          if (retract_left == 0) t_rel = cyc + DC + 1;
        end else if (soft_rst_i) begin
          if (t_rel >= 0 && cyc == t_rel) begin
            retract_left = n_rel + 1;
            t_rel = -1;
          end else if (t_rel >= 0) begin
            if (n_rel == 0) t_rel = cyc + DC + 1;
            else begin retract_left = n_rel; t_rel = -1; end
          end else begin
            retract_left = n_rel;
            awaiting = 1'b0; m_done = 1'b0; m_err = 1'b0; m_fail = 0;
          end
        end else if (t_rel >= 0 && cyc == t_rel) begin
          n_rel++;
          t_rel = -1;
          awaiting = 1'b1;
          t_to = cyc + TC;
        end else if (awaiting) begin
          if (ready_i[n_rel-1]) begin
            awaiting = 1'b0;
            if (n_rel == N) m_done = 1'b1;
            else t_rel = cyc + DC + 1;
          end else if (cyc == t_to) begin
            awaiting = 1'b0;
            m_err = 1'b1;
            m_fail = n_rel - 1;
          end
        end
      end
    end
  end

  logic [N-1:0] e_rst;
  initial begin
    forever begin
      @(negedge clk_i);
      if (chk_on) begin
        e_rst = 4'hF << n_rel;
        chk("model_rst_o", 32'(rst_o), 32'(e_rst));
        chk("model_done_o", 32'(done_o), 32'(m_done));
        chk("model_error_o", 32'(error_o), 32'(m_err));
        if (m_err) chk("model_fail_idx_o", 32'(fail_idx_o), 32'(m_fail));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic por();
    rst_ni = 1'b0;
    tick(2);
    rst_ni = 1'b1;
  endtask

  int offs [3] = '{15, 11, 5};
  int rels [3] = '{25, 21, 14};

  initial begin
    rst_ni = 1'b0; soft_rst_i = 1'b0; ready_i = 4'hF;
    tick(3);
    chk_on = 1'b1;
    chk("reset_rst_o", 32'(rst_o), 32'hF);
    chk("reset_done_o", 32'(done_o), 32'h0);
    chk("reset_error_o", 32'(error_o), 32'h0);
    chk("reset_fail_idx_o", 32'(fail_idx_o), 32'h0);

    // Power-on sequence, all domains ready
    rst_ni = 1'b1;
    tick(10); chk("t1_edge10", 32'(rst_o), 32'hF);
    tick(1);  chk("t1_edge11", 32'(rst_o), 32'hE);
    tick(9);  chk("t1_edge20", 32'(rst_o), 32'hE);
    tick(1);  chk("t1_edge21", 32'(rst_o), 32'hC);
    tick(10); chk("t1_edge31", 32'(rst_o), 32'h8);
    tick(10); chk("t1_edge41", 32'(rst_o), 32'h0);
    chk("t1_done_edge41", 32'(done_o), 32'h0);
    tick(1);  chk("t1_done_edge42", 32'(done_o), 32'h1);
    tick(5);

    // Soft reset from DONE
    soft_rst_i = 1'b1; tick(1); soft_rst_i = 1'b0;
    chk("t3_done_clear", 32'(done_o), 32'h0);
    tick(1); chk("t3_assert3", 32'(rst_o), 32'h8);
    tick(1); chk("t3_assert2", 32'(rst_o), 32'hC);
    tick(1); chk("t3_assert1", 32'(rst_o), 32'hE);
    tick(1); chk("t3_assert0", 32'(rst_o), 32'hF);
    tick(39); chk("t3_all_rel", 32'(rst_o), 32'h0);
    chk("t3_done_pre", 32'(done_o), 32'h0);
    tick(1); chk("t3_done", 32'(done_o), 32'h1);

    // Timeout on domain 2
    ready_i = 4'b1011;
    por();
    tick(31); chk("t2_rel2", 32'(rst_o), 32'h8);
    tick(31); chk("t2_err_pre", 32'(error_o), 32'h0);
    tick(1);
    chk("t2_err", 32'(error_o), 32'h1);
    chk("t2_fail_idx", 32'(fail_idx_o), 32'h2);
    chk("t2_rst_hold", 32'(rst_o), 32'h8);
    chk("t2_done", 32'(done_o), 32'h0);
    tick(10); chk("t2_err_sticky", 32'(error_o), 32'h1);

    // Soft reset out of ERROR
    ready_i = 4'hF;
    soft_rst_i = 1'b1; tick(1); soft_rst_i = 1'b0;
    chk("t4_err_clear", 32'(error_o), 32'h0);
    tick(1); chk("t4_assert2", 32'(rst_o), 32'hC);
    tick(42); chk("t4_done", 32'(done_o), 32'h1);
    tick(5);

    // Async reset pulse while waiting on domain 1
    ready_i = 4'b0001;
    por();
    tick(25); chk("t5_wait1", 32'(rst_o), 32'hC);
    rst_ni = 1'b0; #1;
    chk("t5_async_rst_o", 32'(rst_o), 32'hF);
    chk("t5_async_done", 32'(done_o), 32'h0);
    chk("t5_async_err", 32'(error_o), 32'h0);
    tick(1); rst_ni = 1'b1; ready_i = 4'hF;
    tick(10); chk("t5_edge10", 32'(rst_o), 32'hF);
    tick(1);  chk("t5_edge11", 32'(rst_o), 32'hE);
    tick(30); chk("t5_edge41", 32'(rst_o), 32'h0);
    tick(1);  chk("t5_done", 32'(done_o), 32'h1);
    tick(5);

    // Soft reset and ready[3] in the same WAIT cycle
    ready_i = 4'b0111;
    soft_rst_i = 1'b1; tick(1); soft_rst_i = 1'b0;
    tick(44); chk("t6_wait3", 32'(rst_o), 32'h0);
    soft_rst_i = 1'b1; ready_i = 4'hF;
    tick(1); soft_rst_i = 1'b0;
    chk("t6_no_done", 32'(done_o), 32'h0);
    tick(1); chk("t6_assert3", 32'(rst_o), 32'h8);
    chk("t6_no_done2", 32'(done_o), 32'h0);
    tick(43); chk("t6_done_after", 32'(done_o), 32'h1);

    // Soft pulses landing in HOLD idx>0, in RELEASE, and in HOLD idx=0
    for (int i = 0; i < 3; i++) begin
      por();
      tick(offs[i] - 1);
      soft_rst_i = 1'b1; tick(1); soft_rst_i = 1'b0;
      tick(rels[i] - 1 - offs[i]); chk("soft_pre_rel", 32'(rst_o), 32'hF);
      tick(1); chk("soft_rel", 32'(rst_o), 32'hE);
      tick(40);
    end

    // Soft reset held high keeps every domain in reset
    soft_rst_i = 1'b1;
    tick(30);
    chk("held_rst_o", 32'(rst_o), 32'hF);
    chk("held_done", 32'(done_o), 32'h0);
    soft_rst_i = 1'b0;
    tick(40); chk("held_release_done", 32'(done_o), 32'h1);
    tick(3);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
